// File: rtl/bitmask_encoder_scan.sv
// Serialises a multi-hot vector into one binary index per set bit, lowest or highest first.
// One cycle from accept to first code, then one code per cycle; a stalled beat holds its code.
module bitmask_encoder_scan #(
    parameter int N         = 16,
    parameter int W         = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic         out_last,
    output logic         zero_flag,
    output logic [W:0]   count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_code_q, out_code_d;
    logic         out_last_q, out_last_d;
    logic         zero_q, zero_d;
    logic [W:0]   count_q, count_d;
    logic [N-1:0] pend_nxt;

    // Later matches overwrite earlier ones, so the scan direction picks the winner.
    function automatic logic [W-1:0] prio_enc(input logic [N-1:0] v);
        logic [W-1:0] idx;
        int j;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            j = (MSB_FIRST != 0) ? i : (N - 1 - i);
            if (v[j]) idx = W'(j);
        end
        return idx;
    endfunction

    function automatic logic [W:0] popcnt(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + {{W{1'b0}}, v[i]};
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        out_last_d  = out_last_q;
        zero_d      = 1'b0;
        count_d     = count_q;
        pend_nxt    = pend_q & ~({{(N-1){1'b0}}, 1'b1} << out_code_q);

        if (state_q == IDLE) begin
            if (in_valid) begin
                pend_d  = in_vec;
                count_d = popcnt(in_vec);
                if (in_vec == '0) begin
                    zero_d = 1'b1;
                end else begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_code_d  = prio_enc(in_vec);
                    out_last_d  = (popcnt(in_vec) == (W+1)'(1));
                end
            end
        end else if (out_ready) begin
            if (out_last_q) begin
                state_d     = IDLE;
                pend_d      = '0;
                out_valid_d = 1'b0;
                out_code_d  = '0;
                out_last_d  = 1'b0;
            end else begin
                pend_d     = pend_nxt;
                out_code_d = prio_enc(pend_nxt);
                out_last_d = (popcnt(pend_nxt) == (W+1)'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_code_q  <= '0;
            out_last_q  <= 1'b0;
            zero_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_code_q  <= out_code_d;
            out_last_q  <= out_last_d;
            zero_q      <= zero_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_code  = out_code_q;
    assign out_last  = out_last_q;
    assign zero_flag = zero_q;
    assign count     = count_q;

endmodule

// File: doc/bitmask_encoder_scan.md
Name: bitmask_encoder_scan

Overview:
- Inverse of the team's 4-to-16 decoder tree.
- Accepts a 16-bit multi-hot request vector through a valid/ready handshake.
- Serialises the vector into a stream of 4-bit binary codes, one code per set bit, with valid/ready handshake on the output side.
- Used wherever a decoded one-hot or minterm vector must be turned back into indices, e.g. to drive a downstream decoder tree or to log active minterms.

Parameters:
- N, 16: input vector width; the block is specified and verified at 16 only.
- W, 4: code width, equal to log2(N).
- MSB_FIRST, 0: scan order. 0 emits the lowest set index first; 1 emits the highest set index first.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  N  request vector to encode.
- out_valid  output  1  out_code is valid.
- out_ready  input  1  consumer accepts out_code.
- out_code  output  W  index of the current set bit.
- out_last  output  1  current beat is the final code of this vector.
- zero_flag  output  1  one-cycle pulse: an all-zero vector was accepted.
- count  output  W+1  number of set bits in the last accepted vector.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset is sampled on the clk rising edge and forces:
  - state to IDLE and the pending register to 0;
  - out_valid, out_code, out_last, zero_flag and count to 0.
- in_ready is 1 in the cycle after reset deasserts.
- Reset asserted mid-EMIT discards the remaining pending bits; no further beats are emitted.
- There are two states, IDLE and EMIT. in_ready is 1 exactly when the state is IDLE.
- IDLE:
  - On in_valid && in_ready, capture in_vec into the pending register and register count = popcount(in_vec).
  - If in_vec == 0: pulse zero_flag high for the next cycle only, stay in IDLE, never assert out_valid.
  - Otherwise go to EMIT. out_valid rises the cycle after the accept, giving 1 cycle of input-to-first-code latency.
- EMIT:
  - out_valid = 1.
  - out_code is the priority-encoded index of the pending register: lowest set bit if MSB_FIRST=0, highest set bit if MSB_FIRST=1.
  - out_last = 1 when the pending register has exactly one bit set.
  - On out_valid && out_ready, clear the emitted bit in the pending register. The next code appears the following cycle, so throughput is 1 code per cycle while out_ready is held high.
  - When the out_last beat is accepted, return to IDLE. out_valid is 0 and in_ready is 1 in the next cycle. There is no same-cycle turnaround.
- Backpressure: while out_valid=1 and out_ready=0, out_code, out_last and the pending register must hold stable.
- in_valid is ignored during EMIT. No vector is captured and none is lost, because in_ready=0 tells the producer to hold.
- out_code and out_last are 0 whenever out_valid=0.
- count is held from capture until the next accept. It reaches 16 for 0xFFFF, hence W+1 bits.
- zero_flag and out_valid are never high in the same cycle.

Test Plan:
1. MSB_FIRST=0, accept 0x8421, out_ready=1.
   - out_code 0, 5, 10, 15 on 4 consecutive cycles starting 1 cycle after the accept.
   - out_last only with code 15; count=4; in_ready=1 the cycle after the last beat.
2. MSB_FIRST=1, accept 0x8421.
   - Codes 15, 10, 5, 0; out_last with code 0.
3. Accept 0x0006, out_ready=0 for 3 cycles, then held at 1.
   - Code 1 stable for 4 cycles with out_last=0, then code 2 with out_last=1.
   - Drive in_valid=1 throughout: in_ready stays 0 and no capture occurs.
4. Accept 0x0000.
   - zero_flag=1 for exactly 1 cycle; out_valid never rises; count=0; in_ready stays 1.
5. Accept 0xFFFF with out_ready=1.
   - 16 beats with codes 0..15; count=16; out_last on code 15 only.
6. Accept 0x00FF, assert rst for 1 cycle after 2 beats.
   - Next cycle: out_valid=0, count=0, in_ready=1.
   - A following accept of 0x0100 yields the single code 8 with out_last=1.
